dp_ram_be: RTL and testbench

DP_RAM_BE -- requirements
Module: dp_ram_be

---
 rtl/dp_ram_be.sv | 199 +++++++++++++++++++
 tb/tb_dp_ram_be.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_be.sv
// Dual-port RAM with byte enables, configurable read-during-write, optional output
// register and a zero-fill engine that runs after reset or on request.
module dp_ram_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned CLR_ON_RST = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    output logic                    busy,
    input  logic                    en_a,
    input  logic                    we_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH-1:0]   din_a,
    output logic [DATA_WIDTH-1:0]   dout_a,
    output logic                    rvalid_a,
    input  logic                    en_b,
    input  logic                    we_b,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH-1:0]   din_b,
    output logic [DATA_WIDTH-1:0]   dout_b,
    output logic                    rvalid_b,
    output logic                    collision
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    logic                  w_run;
    logic                  w_acc_a;
    logic                  w_acc_b;
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  w_clr_we;
    logic                  w_coll;
    logic [DATA_WIDTH-1:0] w_old_a;
    logic [DATA_WIDTH-1:0] w_old_b;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    logic [DATA_WIDTH-1:0] r_q1_a;
    logic [DATA_WIDTH-1:0] r_q1_b;
    logic                  r_v1_a;
    logic                  r_v1_b;
    logic                  r_coll;

    // Replace the enabled bytes of a word with the corresponding bytes of din.
    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] din,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = din[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Requests are only honoured in RUN and never while reset is applied.
    assign w_run    = rst_n && (r_state == S_RUN);
    assign w_clr_we = rst_n && (r_state == S_CLEAR);
    assign w_acc_a  = w_run && en_a;
    assign w_acc_b  = w_run && en_b;
    assign w_wr_a   = w_acc_a && we_a;
    assign w_wr_b   = w_acc_b && we_b;
    assign busy     = (r_state == S_CLEAR);

    // Reads see the array before this edge's writes; write-first merges only the own port.
    assign w_old_a = r_mem[addr_a];
    assign w_old_b = r_mem[addr_b];
    assign w_rd_a  = ((RDW_MODE != 0) && we_a) ? f_merge(w_old_a, din_a, be_a) : w_old_a;
    assign w_rd_b  = ((RDW_MODE != 0) && we_b) ? f_merge(w_old_b, din_b, be_b) : w_old_b;
    assign w_coll  = w_wr_a && w_wr_b && (addr_a == addr_b) && (|(be_a & be_b));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= (CLR_ON_RST != 0) ? S_CLEAR : S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_cnt_nxt = ADDR_WIDTH'(r_cnt + 1'b1);
                if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Port A is applied last so it owns any byte both ports enable.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end
        for (int unsigned i = 0; i < NB; i++) begin
            if (w_wr_b && be_b[i]) begin
                r_mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
            end
            if (w_wr_a && be_a[i]) begin
                r_mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q1_a <= '0;
            r_q1_b <= '0;
            r_v1_a <= 1'b0;
            r_v1_b <= 1'b0;
            r_coll <= 1'b0;
        end else begin
            r_v1_a <= w_acc_a;
            r_v1_b <= w_acc_b;
            r_coll <= w_coll;
            if (w_acc_a) begin
                r_q1_a <= w_rd_a;
            end
            if (w_acc_b) begin
                r_q1_b <= w_rd_b;
            end
        end
    end

    assign collision = r_coll;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_q2_a;
            logic [DATA_WIDTH-1:0] r_q2_b;
            logic                  r_v2_a;
            logic                  r_v2_b;

            // Second stage keeps draining during CLEAR so in-flight reads complete.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q2_a <= '0;
                    r_q2_b <= '0;
                    r_v2_a <= 1'b0;
                    r_v2_b <= 1'b0;
                end else begin
                    r_v2_a <= r_v1_a;
                    r_v2_b <= r_v1_b;
                    if (r_v1_a) begin
                        r_q2_a <= r_q1_a;
                    end
                    if (r_v1_b) begin
                        r_q2_b <= r_q1_b;
                    end
                end
            end

            assign dout_a   = r_q2_a;
            assign dout_b   = r_q2_b;
            assign rvalid_a = r_v2_a;
            assign rvalid_b = r_v2_b;
        end else begin : g_no_out_reg
            assign dout_a   = r_q1_a;
            assign dout_b   = r_q1_b;
            assign rvalid_a = r_v1_a;
            assign rvalid_b = r_v1_b;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: two instances (read-first/no out reg, write-first/out reg)
// driven in lockstep and compared every cycle against a word-level memory model.
module tb_dp_ram_be;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          en_a, we_a, en_b, we_b;
    logic [NB-1:0] be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;

    logic          busy0, busy1, rva0, rvb0, rva1, rvb1, coll0, coll1;
    logic [DW-1:0] da0, db0, da1, db1;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy;
    int            m_cnt;
    logic [DW-1:0] e0_da, e0_db, p1_da, p1_db, e1_da, e1_db;
    bit            e0_va, e0_vb, p1_va, p1_vb, e1_va, e1_vb, e_coll;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy0),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(da0), .rvalid_a(rva0),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(db0), .rvalid_b(rvb0), .collision(coll0)
    );

    dp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .OUT_REG(1), .CLR_ON_RST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(da1), .rvalid_a(rva1),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(db1), .rvalid_b(rvb1), .collision(coll1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] bmask(input logic [NB-1:0] be);
        logic [DW-1:0] m;
        for (int i = 0; i < NB; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Predict what the coming clock edge does, from the inputs currently applied.
    task automatic model_step();
        logic [DW-1:0] old_a, old_b, ma, mb;
        if (!rst_n) begin
            e0_da = '0; e0_db = '0; e0_va = 0; e0_vb = 0;
            p1_da = '0; p1_db = '0; p1_va = 0; p1_vb = 0;
            e1_da = '0; e1_db = '0; e1_va = 0; e1_vb = 0;
            e_coll = 0; m_busy = 1; m_cnt = 0;
        end else begin
            e1_va = p1_va;
            e1_vb = p1_vb;
            if (p1_va) e1_da = p1_da;
            if (p1_vb) e1_db = p1_db;
            e_coll = 0;
            if (m_busy) begin
                m_mem[m_cnt] = '0;
                if (m_cnt == DEPTH - 1) m_busy = 0;
                m_cnt = (m_cnt + 1) % DEPTH;
                e0_va = 0; e0_vb = 0; p1_va = 0; p1_vb = 0;
            end else begin
                old_a = m_mem[addr_a];
                old_b = m_mem[addr_b];
                ma = bmask(be_a);
                mb = bmask(be_b);
                e0_va = en_a; e0_vb = en_b;
                p1_va = en_a; p1_vb = en_b;
                if (en_a) begin
                    e0_da = old_a;
                    p1_da = we_a ? ((old_a & ~ma) | (din_a & ma)) : old_a;
                end
                if (en_b) begin
                    e0_db = old_b;
                    p1_db = we_b ? ((old_b & ~mb) | (din_b & mb)) : old_b;
                end
                e_coll = en_a && we_a && en_b && we_b && (addr_a == addr_b) && ((be_a & be_b) != 0);
                if (en_b && we_b) m_mem[addr_b] = (m_mem[addr_b] & ~mb) | (din_b & mb);
                if (en_a && we_a) m_mem[addr_a] = (m_mem[addr_a] & ~ma) | (din_a & ma);
                if (clr) begin
                    m_busy = 1;
                    m_cnt  = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("busy0", 32'(busy0), 32'(m_busy));
        check("busy1", 32'(busy1), 32'(m_busy));
        check("coll0", 32'(coll0), 32'(e_coll));
        check("coll1", 32'(coll1), 32'(e_coll));
        check("rvalid0_a", 32'(rva0), 32'(e0_va));
        check("rvalid0_b", 32'(rvb0), 32'(e0_vb));
        check("rvalid1_a", 32'(rva1), 32'(e1_va));
        check("rvalid1_b", 32'(rvb1), 32'(e1_vb));
        check("dout0_a", da0, e0_da);
        check("dout0_b", db0, e0_db);
        check("dout1_a", da1, e1_da);
        check("dout1_b", db1, e1_db);
    endtask

    task automatic idle();
        clr = 0; en_a = 0; we_a = 0; en_b = 0; we_b = 0;
        be_a = '0; be_b = '0; addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    endtask

    task automatic set_a(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        en_a = 1; we_a = we; be_a = be; addr_a = addr; din_a = din;
    endtask

    task automatic set_b(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        en_b = 1; we_b = we; be_b = be; addr_b = addr; din_b = din;
    endtask

    // Counts cycles with busy high, bounded so a stuck busy cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 64) begin
            n++;
            cycle();
        end
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        rst_n = 0;
        idle();
        cycle();
        cycle();
        check("rst_dout0_a", da0, 32'h0);
        check("rst_rvalid1_b", 32'(rvb1), 32'h0);
        rst_n = 1;

        count_busy(n);
        check("busy_len_reset", 32'(n), 32'd16);

        for (int i = 0; i < DEPTH; i++) begin
            set_a(0, '0, AW'(i), '0);
            set_b(0, '0, AW'(DEPTH - 1 - i), '0);
            cycle();
        end
        idle();
        cycle();

        // Partial byte write merge, read back on B
        set_a(1, 4'b1111, 4'd3, 32'h11223344);
        cycle();
        set_a(1, 4'b0101, 4'd3, 32'hAABBCCDD);
        cycle();
        idle();
        set_b(0, '0, 4'd3, '0);
        cycle();
        check("be_merge0", db0, 32'h11BB33DD);
        check("be_merge0_v", 32'(rvb0), 32'h1);
        idle();
        cycle();
        check("be_merge1", db1, 32'h11BB33DD);
        check("be_merge1_v", 32'(rvb1), 32'h1);

        // Same-cycle write on A, read on B
        set_a(1, 4'b1111, 4'd5, 32'hDEADBEEF);
        set_b(0, '0, 4'd5, '0);
        cycle();
        check("rdw0_a", da0, 32'h0);
        check("rdw0_b", db0, 32'h0);
        idle();
        cycle();
        check("rdw1_a", da1, 32'hDEADBEEF);
        check("rdw1_b", db1, 32'h0);

        // Dual writes to the same address
        set_a(1, 4'b0011, 4'd7, 32'hFFFFFFFF);
        set_b(1, 4'b0110, 4'd7, 32'h12345678);
        cycle();
        check("coll_hit", 32'(coll0), 32'h1);
        idle();
        set_a(0, '0, 4'd7, '0);
        cycle();
        check("dual_wr_ovl", da0, 32'h0034FFFF);
        set_a(1, 4'b0011, 4'd7, 32'hFFFFFFFF);
        set_b(1, 4'b1100, 4'd7, 32'h12345678);
        cycle();
        check("coll_miss", 32'(coll0), 32'h0);
        idle();
        set_a(0, '0, 4'd7, '0);
        cycle();
        check("dual_wr_disj", da0, 32'h1234FFFF);

        // Runtime clear with a read in the clr cycle and a dropped write during busy
        idle();
        set_a(1, 4'b1111, 4'd2, 32'hCAFEF00D);
        cycle();
        idle();
        clr = 1;
        set_a(0, '0, 4'd2, '0);
        cycle();
        check("clr_rd", da0, 32'hCAFEF00D);
        idle();
        set_a(1, 4'b1111, 4'd2, 32'h55555555);
        cycle();
        check("clr_drop_v", 32'(rva0), 32'h0);
        idle();
        count_busy(n);
        check("busy_done", 32'(busy0), 32'h0);
        set_a(0, '0, 4'd2, '0);
        cycle();
        check("clr_rdback", da0, 32'h0);

        // Reset in the middle of a clear restarts the fill
        idle();
        clr = 1;
        cycle();
        clr = 0;
        repeat (8) cycle();
        rst_n = 0;
        cycle();
        check("midrst_rv", 32'(rva0), 32'h0);
        check("midrst_dout", da1, 32'h0);
        rst_n = 1;
        count_busy(n);
        check("busy_len_midrst", 32'(n), 32'd16);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            en_a   = 1'($urandom_range(0, 1));
            we_a   = 1'($urandom_range(0, 1));
            be_a   = NB'($urandom);
            addr_a = AW'($urandom);
            din_a  = $urandom;
            en_b   = 1'($urandom_range(0, 1));
            we_b   = 1'($urandom_range(0, 1));
            be_b   = NB'($urandom);
            addr_b = ($urandom_range(0, 2) == 0) ? addr_a : AW'($urandom);
            din_b  = $urandom;
            clr    = ($urandom_range(0, 59) == 0);
            cycle();
        end
        idle();
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
